input_buffer: RTL and testbench

Memory-mapped input peripheral for the single-cycle RISC-V core, occupying data addresses 0x7800–0x781F on the LSU bus alongside the output buffer at 0x7000–0x703F. It synchronizes 32 slide switches and debounces 4 push-buttons. It captures button press events in sticky write-1-to-clear bits and raises a maskable interrupt line. Load data is returned combinationally to the LSU write-back mux using the same func3 size/sign encoding as the rest of the LSU.

---
 rtl/io_pkg.sv | 17 +
 rtl/input_debounce.sv | 34 +++
 rtl/input_buffer.sv | 82 ++++++++
 tb/tb_input_buffer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// io_pkg: shared LSU access encodings, peripheral address regions and register offsets
package io_pkg;
  localparam logic [2:0] F3_BYTE  = 3'b000;
  localparam logic [2:0] F3_HALF  = 3'b001;
  localparam logic [2:0] F3_WORD  = 3'b010;
  localparam logic [2:0] F3_UBYTE = 3'b100;
  localparam logic [2:0] F3_UHALF = 3'b101;
  localparam logic [15:0] IN_BASE   = 16'h7800;
  localparam logic [15:0] IN_LIMIT  = 16'h781F;
  localparam logic [15:0] OUT_BASE  = 16'h7000;
  localparam logic [15:0] OUT_LIMIT = 16'h703F;
  localparam logic [4:0] OFF_SW     = 5'h00;
  localparam logic [4:0] OFF_BTN    = 5'h10;
  localparam logic [4:0] OFF_EDGE   = 5'h14;
  localparam logic [4:0] OFF_IRQ_EN = 5'h18;
  localparam logic [4:0] OFF_CNT    = 5'h1C;
endpackage

// File: rtl/input_debounce.sv
// input_debounce: 2-FF sync of an active-low button, debounced level and one-cycle press pulse
module input_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);
  localparam int W = $clog2(DEBOUNCE_CYCLES);
  logic [1:0]   r_sync;
  logic [W-1:0] r_cnt;
  logic         r_level;
  logic         w_diff, w_done;
  // the toggle lands on the edge where the count would reach DEBOUNCE_CYCLES-1
  always_comb begin
    w_diff  = ~r_sync[1] ^ r_level;
    w_done  = w_diff && r_cnt == W'(DEBOUNCE_CYCLES - 2);
    o_level = r_level;
    o_rise  = w_done && !r_level;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync  <= 2'b11;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_raw};
      r_cnt   <= (w_diff && !w_done) ? r_cnt + 1'b1 : '0;
      r_level <= w_done ? ~r_level : r_level;
    end
  end
endmodule

// File: rtl/input_buffer.sv
// input_buffer: memory-mapped switches/buttons with sticky press events, press counters and IRQ
module input_buffer
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int NUM_BTN         = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] i_in_buf_addr,
  input  logic [31:0] i_in_buf_data,
  input  logic        i_lsu_wren,
  input  logic [2:0]  i_control,
  input  logic [31:0] i_io_sw,
  input  logic [3:0]  i_io_btn,
  output logic [31:0] o_in_buf_data,
  output logic        o_btn_irq
);
  logic [31:0] r_sw_meta, r_sw, r_cnt;
  logic [3:0]  r_edge, r_irq_en;
  logic [3:0]  w_level, w_rise, w_be, w_clr;
  logic        w_sel, w_wr;
  logic [4:0]  w_off;
  logic [31:0] w_word, w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  genvar n;
  generate
    for (n = 0; n < NUM_BTN; n++) begin : g_btn
      input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_raw   (i_io_btn[n]),
        .o_level (w_level[n]),
        .o_rise  (w_rise[n])
      );
    end
  endgenerate
  // reads and the IRQ are forced low while reset is held, before the first clearing edge
  always_comb begin
    w_sel  = i_rst_n && i_in_buf_addr >= IN_BASE && i_in_buf_addr <= IN_LIMIT;
    w_off  = {i_in_buf_addr[4:2], 2'b00};
    w_word = w_off == OFF_SW     ? r_sw :
             w_off == OFF_BTN    ? {28'h0, w_level} :
             w_off == OFF_EDGE   ? {28'h0, r_edge} :
             w_off == OFF_IRQ_EN ? {28'h0, r_irq_en} :
             w_off == OFF_CNT    ? r_cnt : 32'h0;
    w_byte = w_word[{i_in_buf_addr[1:0], 3'b000} +: 8];
    w_half = i_in_buf_addr[1] ? w_word[31:16] : w_word[15:0];
    o_in_buf_data = !w_sel                ? 32'h0 :
                    i_control == F3_BYTE  ? {{24{w_byte[7]}}, w_byte} :
                    i_control == F3_HALF  ? {{16{w_half[15]}}, w_half} :
                    i_control == F3_WORD  ? w_word :
                    i_control == F3_UBYTE ? {24'h0, w_byte} :
                    i_control == F3_UHALF ? {16'h0, w_half} : 32'h0;
    w_be    = i_control[1:0] == 2'b00 ? 4'b0001 << i_in_buf_addr[1:0] :
              i_control[1:0] == 2'b01 ? 4'b0011 << {i_in_buf_addr[1], 1'b0} :
              i_control[1:0] == 2'b10 ? 4'b1111 : 4'b0000;
    w_wdata = i_control[1:0] == 2'b00 ? i_in_buf_data << {i_in_buf_addr[1:0], 3'b000} :
              i_control[1:0] == 2'b01 ? i_in_buf_data << {i_in_buf_addr[1], 4'b0000} : i_in_buf_data;
    w_wr    = w_sel && i_lsu_wren;
    w_clr   = (w_wr && w_off == OFF_EDGE && w_be[0]) ? w_wdata[3:0] : 4'h0;
    o_btn_irq = i_rst_n && |(r_edge & r_irq_en);
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sw_meta <= '0;
      r_sw      <= '0;
      r_edge    <= '0;
      r_irq_en  <= '0;
      r_cnt     <= '0;
    end else begin
      r_sw_meta <= i_io_sw;
      r_sw      <= r_sw_meta;
      r_edge    <= (r_edge & ~w_clr) | w_rise;
      if (w_wr && w_off == OFF_IRQ_EN && w_be[0]) r_irq_en <= w_wdata[3:0];
      for (int i = 0; i < NUM_BTN; i++)
        if (w_wr && w_off == OFF_CNT && w_be[i]) r_cnt[8*i +: 8] <= w_wdata[8*i +: 8];
        else if (w_rise[i]) r_cnt[8*i +: 8] <= r_cnt[8*i +: 8] + 8'd1;
    end
  end
endmodule

// File: tb/tb_input_buffer.sv
// tb_input_buffer: directed scoreboard bench for input_buffer with DEBOUNCE_CYCLES = 4
`timescale 1ns/1ps
module tb_input_buffer;
  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic        wren;
  logic [2:0]  ctrl;
  logic [31:0] sw;
  logic [3:0]  btn;
  logic [31:0] rdata;
  logic        irq;
  int          passed = 0;
  int          total  = 0;
  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];
  input_buffer #(.DEBOUNCE_CYCLES(4), .NUM_BTN(4)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_in_buf_addr (addr),
    .i_in_buf_data (wdata),
    .i_lsu_wren    (wren),
    .i_control     (ctrl),
    .i_io_sw       (sw),
    .i_io_btn      (btn),
    .o_in_buf_data (rdata),
    .o_btn_irq     (irq)
  );
  always #10 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic push_exp(input string tag, input logic [31:0] e);
    sb.push_back('{tag, e});
  endtask
  task automatic check_out(input logic [31:0] got);
    exp_t x;
    total++;
    if (sb.size() == 0) begin
      $error("FAIL scoreboard_empty: got %h expected <entry>", got);
    end else begin
      x = sb.pop_front();
      assert (got === x.exp) passed++;
      else $error("FAIL %s: got %h expected %h", x.tag, got, x.exp);
    end
  endtask
  task automatic rd(input string tag, input logic [15:0] a, input logic [2:0] c, input logic [31:0] e);
    addr = a;
    ctrl = c;
    push_exp(tag, e);
    #1;
    check_out(rdata);
  endtask
  task automatic chk_irq(input string tag, input logic e);
    push_exp(tag, {31'h0, e});
    #1;
    check_out({31'h0, irq});
  endtask
  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [2:0] c);
    addr  = a;
    wdata = d;
    ctrl  = c;
    wren  = 1'b1;
    tick(1);
    wren  = 1'b0;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    rst_n = 1'b0; sw = 32'hA5A5_0F0F; btn = 4'hF; wren = 1'b0;
    addr = 16'h7800; wdata = 32'h0; ctrl = LW;
    #1;
    rd("rst_sw_pre", 16'h7800, LW, 32'h0);
    rd("rst_cnt_pre", 16'h781C, LW, 32'h0);
    chk_irq("rst_irq_pre", 1'b0);
    tick(2);
    rd("rst_edge", 16'h7814, LW, 32'h0);
    rd("rst_sw", 16'h7800, LW, 32'h0);
    rst_n = 1'b1;
    tick(2);
    rd("sw_lw", 16'h7800, LW, 32'hA5A5_0F0F);
    rd("sw_lb", 16'h7800, LB, 32'h0000_000F);
    rd("sw_lh", 16'h7802, LH, 32'hFFFF_A5A5);
    rd("sw_lhu", 16'h7802, LHU, 32'h0000_A5A5);
    rd("sw_lb3", 16'h7803, LB, 32'hFFFF_FFA5);
    rd("sw_lbu3", 16'h7803, LBU, 32'h0000_00A5);
    btn = 4'b1101;
    tick(4);
    rd("btn_early", 16'h7810, LW, 32'h0);
    tick(1);
    rd("btn_press", 16'h7810, LW, 32'h2);
    rd("edge_press", 16'h7814, LW, 32'h2);
    rd("cnt_press", 16'h781C, LW, 32'h0000_0100);
    chk_irq("irq_masked", 1'b0);
    tick(5);
    btn = 4'hF;
    tick(8);
    rd("btn_release", 16'h7810, LW, 32'h0);
    rd("edge_sticky", 16'h7814, LW, 32'h2);
    for (int g = 0; g < 2; g++) begin
      btn = 4'b1110;
      tick(2);
      btn = 4'hF;
      tick(8);
    end
    rd("glitch_btn", 16'h7810, LW, 32'h0);
    rd("glitch_edge", 16'h7814, LW, 32'h2);
    rd("glitch_cnt", 16'h781C, LW, 32'h0000_0100);
    wr(16'h7818, 32'h2, SW);
    chk_irq("irq_on", 1'b1);
    rd("irq_en_rd", 16'h7818, LW, 32'h2);
    wr(16'h7814, 32'h2, SW);
    chk_irq("irq_w1c", 1'b0);
    rd("edge_w1c", 16'h7814, LW, 32'h0);
    btn = 4'b1101;
    tick(4);
    wr(16'h7814, 32'h2, SW);
    rd("edge_set_wins", 16'h7814, LW, 32'h2);
    rd("cnt_second", 16'h781C, LW, 32'h0000_0200);
    chk_irq("irq_set_wins", 1'b1);
    btn = 4'hF;
    tick(8);
    btn = 4'b1101;
    tick(4);
    wr(16'h781D, 32'h5555_5555, SB);
    rd("cnt_write_wins", 16'h781C, LW, 32'h0000_5500);
    btn = 4'hF;
    tick(8);
    wr(16'h781E, 32'hFFFF_FFFF, SB);
    rd("cnt_preload", 16'h781C, LW, 32'h00FF_5500);
    btn = 4'b1011;
    tick(5);
    rd("cnt_wrap", 16'h781C, LW, 32'h0000_5500);
    rd("edge_btn2", 16'h7814, LW, 32'h6);
    rd("btn2_level", 16'h7810, LW, 32'h4);
    btn = 4'hF;
    tick(8);
    rd("out_hi", 16'h7820, LW, 32'h0);
    rd("out_lo", 16'h77FF, LB, 32'h0);
    rd("bad_f3", 16'h7800, 3'b011, 32'h0);
    rd("unmapped", 16'h7804, LW, 32'h0);
    wr(16'h7800, 32'h0, SW);
    rd("sw_ro", 16'h7800, LW, 32'hA5A5_0F0F);
    wr(16'h7818, 32'h0, 3'b011);
    rd("size11_ignored", 16'h7818, LW, 32'h2);
    wr(16'h7820, 32'h0, SW);
    rd("out_wr_ignored", 16'h7818, LW, 32'h2);
    wr(16'h781E, 32'h0000_BBAA, SH);
    rd("cnt_sh", 16'h781C, LW, 32'hBBAA_5500);
    rd("cnt_lh", 16'h781E, LH, 32'hFFFF_BBAA);
    rd("cnt_lbu", 16'h781D, LBU, 32'h0000_0055);
    rd("cnt_lb3", 16'h781F, LB, 32'hFFFF_FFBB);
    btn = 4'b1110;
    tick(3);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    rd("mid_rst_sw", 16'h7800, LW, 32'h0);
    rd("mid_rst_btn", 16'h7810, LW, 32'h0);
    rd("mid_rst_edge", 16'h7814, LW, 32'h0);
    rd("mid_rst_en", 16'h7818, LW, 32'h0);
    rd("mid_rst_cnt", 16'h781C, LW, 32'h0);
    chk_irq("mid_rst_irq", 1'b0);
    tick(4);
    rd("rewindow_early", 16'h7810, LW, 32'h0);
    tick(1);
    rd("rewindow_btn", 16'h7810, LW, 32'h1);
    rd("rewindow_cnt", 16'h781C, LW, 32'h0000_0001);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
